mem_arbiter_n: RTL and testbench

//  N-way arbiter between cache/LSU requesters and the single-port main memory; line-granular
//  (DATA_W) reads/writes, one transaction in flight. Successor of the 2-port I/D arbiter:

---
 rtl/mem_arbiter_n.sv | 125 ++++++++++++
 tb/tb_mem_arbiter_n.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_n.sv
// N-way arbiter in front of a single-port main memory, one line transaction in flight.
// Optional round-robin selection when MEM_ARB_RR_EN is defined; fixed priority (lowest index) otherwise.
module mem_arbiter_n #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 128,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_rdata,
    output logic [ADDR_W-1:0]         resp_addr,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_ready,
    input  logic [ADDR_W-1:0]         mem_resp_addr,
    output logic                      busy,
    output logic [IDX_W-1:0]          owner
);

    // state | meaning
    // IDLE  | no transaction in flight; winner launched combinationally
    // BUSY  | transaction in flight for owner; waiting for mem_ready
    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] winner;
    logic             any_req;

    assign any_req = |req_valid;

`ifdef MEM_ARB_RR_EN
    logic [IDX_W-1:0] rr_last;
    logic             found;
    int               idx;

    // Search starts just after the last granted index, wrapping modulo NUM_REQ.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_last) + 1 + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                winner = IDX_W'(idx);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_last <= IDX_W'(NUM_REQ - 1);
        else if (state == IDLE && any_req)
            rr_last <= winner;
    end
`else
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i])
                winner = IDX_W'(i);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req)
                owner <= winner;
        end
    end

    // Launch fields are only driven in IDLE so memory never sees a duplicate accept.
    always_comb begin
        state_nxt  = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        resp_valid = '0;
        resp_rdata = '0;
        resp_addr  = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = BUSY;
                    mem_req   = 1'b1;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (IDX_W'(i) == winner) begin
                            mem_we    = req_we[i];
                            mem_addr  = req_addr[i*ADDR_W +: ADDR_W];
                            mem_wdata = req_wdata[i*DATA_W +: DATA_W];
                        end
                    end
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_nxt  = IDLE;
                    resp_rdata = mem_rdata;
                    resp_addr  = mem_resp_addr;
                    for (int i = 0; i < NUM_REQ; i++)
                        resp_valid[i] = (IDX_W'(i) == owner);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == BUSY);

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Randomized bench for mem_arbiter_n: requesters hold requests until served, a memory model
// answers after a random latency, and a queue-free reference picks the expected winner.
module tb_mem_arbiter_n;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    resp_valid;
    logic [DW-1:0]   resp_rdata;
    logic [AW-1:0]   resp_addr;
    logic            mem_req, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata = '0;
    logic            mem_ready = 1'b0;
    logic [AW-1:0]   mem_resp_addr = '0;
    logic            busy;
    logic [1:0]      owner;

    always #5 clk = ~clk;

    mem_arbiter_n #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_addr(resp_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_resp_addr(mem_resp_addr),
        .busy(busy), .owner(owner)
    );

    // Pending requests as seen by the requesters themselves.
    logic [N-1:0]  pend = '0;
    logic [N-1:0]  we_q = '0;
    logic [AW-1:0] addr_q [N];
    logic [DW-1:0] wd_q [N];
    int            rr_last = N - 1;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] m);
`ifdef MEM_ARB_RR_EN
        for (int k = 1; k <= N; k++)
            if (m[(rr_last + k) % N]) return (rr_last + k) % N;
`else
        for (int i = 0; i < N; i++)
            if (m[i]) return i;
`endif
        return 0;
    endfunction

    task automatic drive_reqs(input logic [N-1:0] vmask);
        req_valid = vmask;
        for (int i = 0; i < N; i++) begin
            req_we[i]              = we_q[i];
            req_addr[i*AW +: AW]   = addr_q[i];
            req_wdata[i*DW +: DW]  = wd_q[i];
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend[i]   = 1'b1;
        we_q[i]   = we;
        addr_q[i] = a;
        wd_q[i]   = d;
    endtask

    task automatic new_reqs();
        for (int i = 0; i < N; i++)
            if (!pend[i] && $urandom_range(0, 1) == 1)
                set_req(i, 1'($urandom), $urandom, {$urandom, $urandom});
        if (pend == '0)
            set_req(int'($urandom_range(0, N - 1)), 1'($urandom), $urandom, {$urandom, $urandom});
    endtask

    // Launch the expected winner, hold BUSY for lat cycles, then complete it.
    task automatic run_txn(input bit drop_owner, input int lat, input logic [DW-1:0] rd);
        int w;
        logic [N-1:0] during;
        w = pick(pend);
        @(negedge clk);
        drive_reqs(pend);
        mem_ready = 1'b0; mem_rdata = '0; mem_resp_addr = '0;
        #1;
        chk("launch_busy", busy, 0);
        chk("launch_req", mem_req, 1);
        chk("launch_we", mem_we, we_q[w]);
        chk("launch_addr", mem_addr, addr_q[w]);
        chk("launch_wdata", mem_wdata, wd_q[w]);
        chk("launch_resp", resp_valid, 0);
        @(posedge clk); #1;
        chk("grant_owner", owner, w);
        chk("grant_busy", busy, 1);
        rr_last = w;
        during = drop_owner ? (pend & ~(N'(1) << w)) : pend;
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            drive_reqs(during);
            #1;
            chk("busy_noreq", mem_req, 0);
            chk("busy_nowe", mem_we, 0);
            chk("busy_noaddr", mem_addr, 0);
            chk("busy_nowdata", mem_wdata, 0);
            chk("busy_noresp", resp_valid, 0);
            chk("busy_nordata", resp_rdata, 0);
        end
        @(negedge clk);
        drive_reqs(during);
        mem_ready = 1'b1; mem_rdata = rd; mem_resp_addr = addr_q[w];
        #1;
        chk("done_resp", resp_valid, N'(1) << w);
        chk("done_rdata", resp_rdata, rd);
        chk("done_addr", resp_addr, addr_q[w]);
        chk("done_noreq", mem_req, 0);
        @(posedge clk); #1;
        chk("done_idle", busy, 0);
        pend[w] = 1'b0;
    endtask

    task automatic spurious_ready();
        @(negedge clk);
        drive_reqs('0);
        mem_ready = 1'b1; mem_rdata = {$urandom, $urandom}; mem_resp_addr = $urandom;
        #1;
        chk("spur_resp", resp_valid, 0);
        chk("spur_busy", busy, 0);
        chk("spur_req", mem_req, 0);
        @(posedge clk); #1;
        chk("spur_stay_idle", busy, 0);
        chk("spur_resp_after", resp_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            addr_q[i] = '0;
            wd_q[i]   = '0;
        end
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_memreq", mem_req, 0);
        chk("rst_resp", resp_valid, 0);
        #20 rst_n = 1'b1;

        // Single read from requester 0.
        set_req(0, 1'b0, 32'h100, '0);
        run_txn(1'b0, 2, 64'hA5A5_A5A5_A5A5_A5A5);

        // Write from requester 1.
        set_req(1, 1'b1, 32'h2000, 64'hDEAD_BEEF_DEAD_BEEF);
        run_txn(1'b0, 1, '0);

        spurious_ready();

        // Full contention held across several grants.
        for (int i = 0; i < N; i++)
            set_req(i, 1'($urandom), $urandom, {$urandom, $urandom});
        for (int t = 0; t < N + 1; t++) begin
            run_txn(1'b0, int'($urandom_range(0, 2)), {$urandom, $urandom});
            if (pend == '0)
                set_req(0, 1'b0, $urandom, '0);
        end

        // Randomized traffic with occasional owner drop and spurious ready.
        for (int r = 0; r < 60; r++) begin
            if ($urandom_range(0, 7) == 0 && pend == '0)
                spurious_ready();
            new_reqs();
            run_txn($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)), {$urandom, $urandom});
        end

        // Reset in the middle of a transaction.
        new_reqs();
        @(negedge clk);
        drive_reqs(pend);
        mem_ready = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_busy", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        mem_ready = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_owner", owner, 0);
        chk("midrst_resp", resp_valid, 0);
        chk("midrst_memreq", mem_req, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        pend = '0;
        rr_last = N - 1;
        set_req(2, 1'b0, 32'h300, '0);
        set_req(3, 1'b1, 32'h400, 64'h1234);
        run_txn(1'b0, 1, 64'h5555);
        run_txn(1'b0, 0, 64'h6666);

        @(negedge clk);
        req_valid = '0;
        mem_ready = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
